// File: rtl/alu_pkg.sv
// Shared ALU/writeback definitions: flag positions, opcodes, branch condition codes,
// the write-buffer entry type and the branch condition evaluator.
package alu_pkg;

  localparam int FLAG_S = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SHL   = 6'h05;
  localparam logic [5:0] OP_SHR   = 6'h06;
  localparam logic [5:0] OP_COMP  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_COMPI = 6'h0F;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_MI = 3'd3;
  localparam logic [2:0] COND_PL = 3'd4;
  localparam logic [2:0] COND_CS = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_SS = 3'd7;

  typedef struct packed {
    logic [ALU_REG_AW-1:0] rd;
    logic [ALU_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic cond_eval(input logic [4:0] st, input logic [2:0] sel);
    logic res;
    case (sel)
      COND_AL: res = 1'b1;
      COND_EQ: res = st[FLAG_Z];
      COND_NE: res = !st[FLAG_Z];
      COND_MI: res = st[FLAG_N];
      COND_PL: res = !st[FLAG_N];
      COND_CS: res = st[FLAG_C];
      COND_VS: res = st[FLAG_V];
      default: res = st[FLAG_S];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// Writeback stage bus: ALU result input handshake plus register-file write port.
interface alu_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [4:0]        in_flags;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_we;
  logic              in_flag_we;
  logic              rf_we;
  logic [REG_AW-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_ack;

  modport master (
    output in_valid, in_result, in_flags, in_rd, in_reg_we, in_flag_we, rf_ack,
    input  in_ready, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_rd, in_reg_we, in_flag_we, rf_ack,
    output in_ready, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/alu_wb_stage_wb_fifo.sv
// In-order write buffer for the writeback stage; DEPTH must be a power of two.
// ready is a registered not-full, so a full buffer cannot push even while popping.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clkout,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             do_push, do_pop;

  assign do_push  = push && ready;
  assign do_pop   = pop && (cnt != '0);
  assign empty    = (cnt == '0);
  assign pop_data = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop)
      cnt_nxt = cnt + CW'(1);
    else if (!do_push && do_pop)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      if (do_push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr + AW'(1);
      cnt   <= cnt_nxt;
      ready <= (cnt_nxt != CW'(DEPTH));
    end
  end

  // Storage needs no reset: entries are only visible through cnt.
  always_ff @(posedge clkout) begin
    if (do_push)
      mem[wptr] <= push_data;
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: queues register writes, holds the [SZNVC] status register and
// evaluates branch conditions. Define ALU_WB_FWD_EN to add the fwd_* bypass port.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clkout,
  input  logic              rst_n,
  alu_wb_stage_if.slave     bus,
  input  logic [2:0]        cond_sel,
  output logic              cond_true,
  output logic [4:0]        status
`ifdef ALU_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);
  localparam int EW = DATA_W + REG_AW;

  logic          accept, push, pop, empty;
  logic [EW-1:0] head;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && bus.in_reg_we;
  assign pop    = !empty && bus.rf_ack;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clkout    (clkout),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.in_rd, bus.in_result}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty),
    .ready     (bus.in_ready)
  );

  assign bus.rf_we   = !empty;
  assign bus.rf_addr = head[EW-1:DATA_W];
  assign bus.rf_data = head[DATA_W-1:0];

  // Status follows ALU order, so it can run ahead of the queued register write.
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n)
      status <= 5'b00000;
    else if (accept && bus.in_flag_we)
      status <= bus.in_flags;
  end

  assign cond_true = cond_eval(status, cond_sel);

`ifdef ALU_WB_FWD_EN
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= push;
      if (push) begin
        fwd_addr <= bus.in_rd;
        fwd_data <= bus.in_result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_alu_wb_stage;
  import alu_pkg::*;

  localparam int DEPTH = 2;

  logic       clkout = 1'b0;
  logic       rst_n;
  logic [2:0] cond_sel;
  logic       cond_true;
  logic [4:0] status;

  always #5 clkout = ~clkout;

  alu_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  alu_wb_stage #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
    .clkout    (clkout),
    .rst_n     (rst_n),
    .bus       (bus),
    .cond_sel  (cond_sel),
    .cond_true (cond_true),
    .status    (status)
  );

  int        checks = 0;
  int        errors = 0;
  wb_entry_t mq[$];
  logic [4:0] m_status;
  logic       m_ready;

  function automatic logic ref_cond(input logic [4:0] st, input logic [2:0] sel);
    logic [7:0] tbl;
    tbl = {st[FLAG_S], st[FLAG_V], st[FLAG_C], ~st[FLAG_N], st[FLAG_N],
           ~st[FLAG_Z], st[FLAG_Z], 1'b1};
    return tbl[sel];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rf_we", 64'(bus.rf_we), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rf_addr", 64'(bus.rf_addr), 64'(mq[0].rd));
      chk("rf_data", 64'(bus.rf_data), 64'(mq[0].data));
    end
    chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
    chk("status", 64'(status), 64'(m_status));
    chk("cond_true", 64'(cond_true), 64'(ref_cond(m_status, cond_sel)));
  endtask

  // Called just after a falling edge: drive, check, advance model, move to next falling edge.
  task automatic cycle(input logic v, input logic [31:0] res, input logic [4:0] fl,
                       input logic [4:0] rd, input logic rwe, input logic fwe,
                       input logic ack, input logic [2:0] cs);
    logic acc;
    bus.in_valid   = v;
    bus.in_result  = res;
    bus.in_flags   = fl;
    bus.in_rd      = rd;
    bus.in_reg_we  = rwe;
    bus.in_flag_we = fwe;
    bus.rf_ack     = ack;
    cond_sel       = cs;
    #1;
    check_outputs();
    acc = v && m_ready;
    if (ack && mq.size() != 0)
      void'(mq.pop_front());
    if (acc && rwe)
      mq.push_back('{rd: rd, data: res});
    if (acc && fwe)
      m_status = fl;
    m_ready = (mq.size() < DEPTH);
    @(posedge clkout);
    @(negedge clkout);
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0, ack, 3'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.rf_ack   = 1'b0;
    cond_sel     = 3'd0;
    mq.delete();
    m_status = 5'b00000;
    m_ready  = 1'b1;
    #1;
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_cond_al", 64'(cond_true), 64'd1);
    cond_sel = 3'd5;
    #1;
    chk("rst_cond_cs", 64'(cond_true), 64'd0);
    @(negedge clkout);
    rst_n = 1'b1;
    @(negedge clkout);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_result  = '0;
    bus.in_flags   = '0;
    bus.in_rd      = '0;
    bus.in_reg_we  = 1'b0;
    bus.in_flag_we = 1'b0;
    bus.rf_ack     = 1'b0;
    cond_sel       = 3'd0;
    @(negedge clkout);
    do_reset();

    // Single ADD result to r3
    cycle(1'b1, 32'h0000_0005, 5'b00000, 5'd3, 1'b1, 1'b1, 1'b1, 3'd0);
    #1;
    chk("single_we", 64'(bus.rf_we), 64'd1);
    chk("single_addr", 64'(bus.rf_addr), 64'd3);
    chk("single_data", 64'(bus.rf_data), 64'd5);
    idle(1'b1);
    #1;
    chk("single_popped", 64'(bus.rf_we), 64'd0);

    // Backpressure: three back-to-back results, ack held low
    cycle(1'b1, 32'hA0A0_0001, 5'b00000, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 32'hB0B0_0002, 5'b00000, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 32'hC0C0_0003, 5'b00000, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("bp_head_stable", 64'(bus.rf_data), 64'hA0A0_0001);
    cycle(1'b1, 32'hC0C0_0003, 5'b00000, 5'd4, 1'b1, 1'b0, 1'b1, 3'd0);
    #1;
    chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
    chk("bp_second", 64'(bus.rf_addr), 64'd2);
    cycle(1'b1, 32'hC0C0_0003, 5'b00000, 5'd4, 1'b1, 1'b0, 1'b1, 3'd0);
    #1;
    chk("bp_third", 64'(bus.rf_data), 64'hC0C0_0003);
    idle(1'b1);
    idle(1'b1);

    // COMP: flags only
    cycle(1'b1, 32'h1234_5678, 5'b01000, 5'd9, 1'b0, 1'b1, 1'b1, 3'd0);
    cond_sel = COND_EQ;
    #1;
    chk("comp_no_we", 64'(bus.rf_we), 64'd0);
    chk("comp_status", 64'(status), 64'h08);
    chk("comp_eq", 64'(cond_true), 64'd1);
    cond_sel = COND_NE;
    #1;
    chk("comp_ne", 64'(cond_true), 64'd0);
    idle(1'b0);

    // Push and pop in the same cycle
    cycle(1'b1, 32'h1111_1111, 5'b00001, 5'd5, 1'b1, 1'b1, 1'b0, 3'd5);
    cycle(1'b1, 32'h2222_2222, 5'b10000, 5'd6, 1'b1, 1'b1, 1'b1, 3'd7);
    #1;
    chk("pp_we", 64'(bus.rf_we), 64'd1);
    chk("pp_addr", 64'(bus.rf_addr), 64'd6);
    chk("pp_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);

    // Reset mid-drain: queued entries must never appear
    cycle(1'b1, 32'hDEAD_0001, 5'b00100, 5'd10, 1'b1, 1'b1, 1'b0, 3'd0);
    cycle(1'b1, 32'hDEAD_0002, 5'b00100, 5'd11, 1'b1, 1'b1, 1'b0, 3'd0);
    do_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 3'($urandom));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
